// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver state encoding and the
//                bit-period terminal-count helper used by both RX and TX.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    // Terminal count of the bit-period counter; one bit lasts this value + 1 clocks.
    function automatic int calc_cycles_per_bit(input int clock_rate, input int baud_rate);
        return (clock_rate / baud_rate) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_counter
//  Description : Bit-period counter with synchronous clear, half-point tick
//                and terminal tick. Wraps to zero after the terminal count.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_counter #(
    parameter int CYCLES_PER_BIT = 9
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_half_tick,
    output logic o_term_tick
);

    localparam int c_cnt_w = (CYCLES_PER_BIT > 0) ? $clog2(CYCLES_PER_BIT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CYCLES_PER_BIT / 2);
    localparam logic [c_cnt_w-1:0] c_term = c_cnt_w'(CYCLES_PER_BIT);

    logic [c_cnt_w-1:0] count_q;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            count_q <= '0;
        end else if (count_q == c_term) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + c_cnt_w'(1);
        end
    end

    assign o_half_tick = (count_q == c_half);
    assign o_term_tick = (count_q == c_term);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver (8N1 / 8E1) with mid-bit sampling,
//                single-cycle valid strobe and per-frame error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE     = 50000000,
    parameter int BAUD_RATE      = 9600,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_EN      = 0,
    parameter int CYCLES_PER_BIT = calc_cycles_per_bit(CLOCK_RATE, BAUD_RATE)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int c_idx_w = $clog2(DATA_BITS + 1);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DATA_BITS - 1);

    logic                 rx_meta_q;
    logic                 rx_s_q;
    uart_state_e          state_q;
    logic [c_idx_w-1:0]   bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;

    logic w_half_tick;
    logic w_term_tick;
    logic w_cnt_clear;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Restarting at the start-bit mid-point aligns every later terminal tick to a bit centre.
    assign w_cnt_clear = (state_q == ST_IDLE) || (state_q == ST_BREAK) ||
                         ((state_q == ST_START) && w_half_tick);

    uart_baud_counter #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT)
    ) u_baud_counter (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_cnt_clear),
        .o_half_tick (w_half_tick),
        .o_term_tick (w_term_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_half_tick) begin
                        if (!rx_s_q) begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_term_tick) begin
                        shift_q   <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + c_idx_w'(1);
                        if (bit_idx_q == c_last_idx) begin
                            state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_term_tick) begin
                        parity_q <= rx_s_q;
                        state_q  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_term_tick) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                        ferr_q  <= ~rx_s_q;
                        perr_q  <= (PARITY_EN != 0) && (parity_q != (^shift_q));
                        state_q <= rx_s_q ? ST_IDLE : ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (rx_s_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Scoreboard bench for uart_rx, 10 clocks per bit; one 8N1
//                instance and one 8E1 instance on separate lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;

    logic [7:0] data0, data1;
    logic       valid0, valid1, pe0, pe1, fe0, fe1, busy0, busy1;

    always #5 clk = ~clk;

    uart_rx #(
        .CLOCK_RATE (1000000),
        .BAUD_RATE  (100000),
        .DATA_BITS  (8),
        .PARITY_EN  (0)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_rx         (rx0),
        .o_data       (data0),
        .o_valid      (valid0),
        .o_parity_err (pe0),
        .o_frame_err  (fe0),
        .o_busy       (busy0)
    );

    uart_rx #(
        .CLOCK_RATE (1000000),
        .BAUD_RATE  (100000),
        .DATA_BITS  (8),
        .PARITY_EN  (1)
    ) dut_p (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_rx         (rx1),
        .o_data       (data1),
        .o_valid      (valid1),
        .o_parity_err (pe1),
        .o_frame_err  (fe1),
        .o_busy       (busy1)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the 8N1 instance; also checks o_busy the cycle after each strobe.
    logic busy_chk0 = 1'b0;
    logic exp_busy0 = 1'b0;
    always @(negedge clk) begin : mon0
        exp_t e;
        if (busy_chk0) begin
            chk("busy_after_strobe0", {31'd0, busy0}, {31'd0, exp_busy0});
            busy_chk0 = 1'b0;
        end
        if (valid0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe0: got data %0h expected no strobe", data0);
            end else begin
                e = q0.pop_front();
                chk("data0", {24'd0, data0}, {24'd0, e.d});
                chk("parity_err0", {31'd0, pe0}, {31'd0, e.pe});
                chk("frame_err0", {31'd0, fe0}, {31'd0, e.fe});
                exp_busy0 = e.fe;
                busy_chk0 = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (valid1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe1: got data %0h expected no strobe", data1);
            end else begin
                e = q1.pop_front();
                chk("data1", {24'd0, data1}, {24'd0, e.d});
                chk("parity_err1", {31'd0, pe1}, {31'd0, e.pe});
                chk("frame_err1", {31'd0, fe1}, {31'd0, e.fe});
            end
        end
    end

    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) rx0 = v;
        else            rx1 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int which, input logic [7:0] b, input bit use_par,
                        input logic par, input logic stop_v, input int stop_n,
                        input logic exp_pe, input logic exp_fe);
        exp_t e;
        e.d  = b;
        e.pe = exp_pe;
        e.fe = exp_fe;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
        drive(which, 1'b0, 10);
        for (int i = 0; i < 8; i++) drive(which, b[i], 10);
        if (use_par) drive(which, par, 10);
        drive(which, stop_v, stop_n);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_data0"},  {24'd0, data0},  32'd0);
        chk({tag, "_valid0"}, {31'd0, valid0}, 32'd0);
        chk({tag, "_pe0"},    {31'd0, pe0},    32'd0);
        chk({tag, "_fe0"},    {31'd0, fe0},    32'd0);
        chk({tag, "_busy0"},  {31'd0, busy0},  32'd0);
    endtask

    initial begin
        logic [7:0] partial;
        partial = 8'hF0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        chk("reset_data1", {24'd0, data1}, 32'd0);
        chk("reset_busy1", {31'd0, busy1}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single clean frame.
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0);
        drive(0, 1'b1, 20);

        // Back-to-back frames, no idle gap.
        send(0, 8'h00, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0);
        send(0, 8'hFF, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0);
        send(0, 8'h3C, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0);
        drive(0, 1'b1, 20);

        // Short glitch: START must abort at the half-bit.
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 8);
        chk("glitch_busy_mid", {31'd0, busy0}, 32'd0);
        drive(0, 1'b1, 20);

        // Stop bit held low: frame error, then BREAK until the line recovers.
        send(0, 8'h55, 1'b0, 1'b0, 1'b0, 20, 1'b0, 1'b1);
        chk("break_busy", {31'd0, busy0}, 32'd1);
        drive(0, 1'b1, 20);
        chk("break_exit_busy", {31'd0, busy0}, 32'd0);
        send(0, 8'h12, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0);
        drive(0, 1'b1, 20);

        // Even parity on the 8E1 instance: 0x07 has odd weight, so parity bit 1 is correct.
        send(1, 8'h07, 1'b1, 1'b1, 1'b1, 10, 1'b0, 1'b0);
        drive(1, 1'b1, 20);
        send(1, 8'h07, 1'b1, 1'b0, 1'b1, 10, 1'b1, 1'b0);
        drive(1, 1'b1, 20);
        send(1, 8'hC3, 1'b1, 1'b0, 1'b1, 10, 1'b0, 1'b0);
        drive(1, 1'b1, 20);

        // Reset during data bit 4: partial frame dropped, outputs cleared.
        chk("pre_reset_data0", {24'd0, data0}, 32'h12);
        drive(0, 1'b0, 10);
        for (int i = 0; i < 4; i++) drive(0, partial[i], 10);
        drive(0, partial[4], 5);
        rst = 1'b1;
        rx0 = 1'b1;
        @(negedge clk);
        check_cleared("midreset");
        rst = 1'b0;
        drive(0, 1'b1, 30);
        chk("post_reset_busy0", {31'd0, busy0}, 32'd0);
        send(0, 8'h81, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0);
        drive(0, 1'b1, 30);

        chk("missing_strobes0", q0.size(), 32'd0);
        chk("missing_strobes1", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
